// File: rtl/controlador_suma_pkg.sv
// Shared types and constants for the serial add/subtract controller.
// Optional flags output (Z, V) is enabled with CONTROLADOR_SUMA_FLAGS_EN.
package controlador_suma_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select encoding for the op input
    localparam logic OP_SUMA  = 1'b0;
    localparam logic OP_RESTA = 1'b1;

endpackage

// File: rtl/sumadorCompletoCuatroBits.sv
// Existing 4-bit ripple-carry adder shared by the serial controller.
module sumadorCompletoCuatroBits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] w_c;

    assign w_c[0] = Cin;

    // One full-adder cell per bit, carry rippling upward
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign S[gi]       = A[gi] ^ B[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = w_c[4];

endmodule

// File: rtl/controlador_suma_serial.sv
// Multi-cycle add/subtract controller: walks wide operands through one shared
// 4-bit adder, LSB nibble first, carrying between nibbles in a register.
// Handshake: start is sampled only in IDLE; busy is high from the accepted
// start edge through the DONE cycle; done pulses for one cycle when R/Cout
// are valid. R/Cout hold until the next accepted start.
// Optional Z/V flags are added when CONTROLADOR_SUMA_FLAGS_EN is defined.
module controlador_suma_serial
    import controlador_suma_pkg::*;
#(
    parameter  int N_NIBBLES = 4,
    localparam int W         = 4 * N_NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] R,
    output logic         Cout,
    output logic         busy,
    output state_t       o_dbg_state,
    output logic         done
`ifdef CONTROLADOR_SUMA_FLAGS_EN
    ,
    output logic         Z,
    output logic         V
`endif
);

    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_c;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_op;
    logic [W-1:0]     r_r;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic             w_carry;
    logic [W-1:0]     w_r_next;

    // Operand nibble selection; B is inverted for subtraction
    always_comb begin
        w_a_nib = r_a[r_idx * 4 +: 4];
        w_b_nib = r_b[r_idx * 4 +: 4];
        if (r_op == OP_RESTA) begin
            w_b_nib = ~w_b_nib;
        end
    end

    sumadorCompletoCuatroBits u_sumador (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_c),
        .S    (w_sum),
        .Cout (w_carry)
    );

    // Result with the current nibble replaced by the adder sum
    always_comb begin
        w_r_next = r_r;
        w_r_next[r_idx * 4 +: 4] = w_sum;
    end

`ifdef CONTROLADOR_SUMA_FLAGS_EN
    logic r_z;
    logic r_v;
    logic w_c_msb;

    // Carry into the MSB recovered from the MSB sum bit and its operands
    assign w_c_msb = w_sum[3] ^ w_a_nib[3] ^ w_b_nib[3];
`endif

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_SUMA;
            r_r     <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CONTROLADOR_SUMA_FLAGS_EN
            r_z     <= 1'b0;
            r_v     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op;
                        // Subtraction is A + ~B + 1, so the first carry-in is op
                        r_c     <= (op == OP_SUMA) ? 1'b0 : 1'b1;
                        r_idx   <= '0;
                        r_r     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_r   <= w_r_next;
                    r_c   <= w_carry;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_carry;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef CONTROLADOR_SUMA_FLAGS_EN
                        r_z     <= (w_r_next == '0);
                        r_v     <= w_c_msb ^ w_carry;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign R           = r_r;
    assign Cout        = r_cout;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;
`ifdef CONTROLADOR_SUMA_FLAGS_EN
    assign Z           = r_z;
    assign V           = r_v;
`endif

endmodule

// File: tb/tb_controlador_suma_serial.sv
// Testbench for controlador_suma_serial (default 4 nibbles, 16-bit operands).
// Flag outputs are checked when CONTROLADOR_SUMA_FLAGS_EN is defined.
module tb_controlador_suma_serial;
    import controlador_suma_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic [W-1:0] R;
    logic         Cout;
    logic         busy;
    logic         done;
    state_t       dbg_state;
`ifdef CONTROLADOR_SUMA_FLAGS_EN
    logic         Z;
    logic         V;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {V, Z, Cout, R}
    logic [W+2:0] exp_q[$];

    controlador_suma_serial #(.N_NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .R           (R),
        .Cout        (Cout),
        .busy        (busy),
        .o_dbg_state (dbg_state),
        .done        (done)
`ifdef CONTROLADOR_SUMA_FLAGS_EN
        ,
        .Z           (Z),
        .V           (V)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole operands
    function automatic logic [W+2:0] model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb, full, sres, modv, half;
        logic [63:0] full_bits;
        logic [W-1:0] r;
        logic c, z, v;
        modv = longint'(1) << W;
        half = longint'(1) << (W - 1);
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= half) ? ua - modv : ua;
        sb = (ub >= half) ? ub - modv : ub;
        if (o == OP_SUMA) begin
            full = ua + ub;
            c    = (full >= modv);
            sres = sa + sb;
        end else begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end
        full_bits = full;
        r = full_bits[W-1:0];
        z = (r == '0);
        v = (sres > half - 1) || (sres < -half);
        return {v, z, c, r};
    endfunction

    // Drive one operation and check latency, busy window and result
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit pulse_again, input string tag);
        logic [W+2:0] e;
        int cycles;
        int busy_cnt;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        start    = 1'b0;
        cycles   = 1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cycles < 20) begin
            op    = 1'($urandom_range(0, 1));
            A     = W'($urandom);
            B     = W'($urandom);
            start = pulse_again && (cycles == 2);
            @(posedge clk); #1;
            cycles++;
            if (busy === 1'b1) busy_cnt++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_latency"}, 64'(cycles), 64'(N + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
        check({tag, "_R"}, 64'(R), 64'(e[W-1:0]));
        check({tag, "_Cout"}, 64'(Cout), 64'(e[W]));
`ifdef CONTROLADOR_SUMA_FLAGS_EN
        check({tag, "_Z"}, 64'(Z), 64'(e[W+1]));
        check({tag, "_V"}, 64'(V), 64'(e[W+2]));
`endif
        @(posedge clk); #1;
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_R_hold"}, 64'(R), 64'(e[W-1:0]));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_R", 64'(R), 64'd0);
        check("rst_Cout", 64'(Cout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of RUN discards the operation
        op = OP_SUMA; A = 16'h1111; B = 16'h2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_R", 64'(R), 64'd0);
        check("midrst_Cout", 64'(Cout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("after_rst_busy", 64'(busy), 64'd0);
        check("after_rst_done", 64'(done), 64'd0);
        check("after_rst_state", 64'(dbg_state), 64'(IDLE));
        run_op(OP_SUMA, 16'h0001, 16'h0001, 1'b0, "one_plus_one");
        check("one_plus_one_const", 64'(R), 64'h0002);

        // Directed operations
        run_op(OP_SUMA, 16'h1234, 16'h0FFF, 1'b0, "add_1234");
        check("add_1234_const", 64'(R), 64'h2233);
        run_op(OP_SUMA, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
        check("add_wrap_cout_const", 64'(Cout), 64'd1);
        run_op(OP_RESTA, 16'h0005, 16'h0007, 1'b0, "sub_borrow");
        check("sub_borrow_const", 64'(R), 64'hFFFE);
        run_op(OP_RESTA, 16'h0007, 16'h0005, 1'b0, "sub_noborrow");
        check("sub_noborrow_cout_const", 64'(Cout), 64'd1);
        run_op(OP_SUMA, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        check("add_ovf_const", 64'(R), 64'h8000);
        run_op(OP_RESTA, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
        run_op(OP_RESTA, 16'h1234, 16'h0000, 1'b0, "sub_zero");

        // Start pulsed while busy is ignored; next start right after done is accepted
        run_op(OP_SUMA, 16'h0100, 16'h0020, 1'b1, "ignored_start");
        check("ignored_start_const", 64'(R), 64'h0120);
        run_op(OP_RESTA, 16'h0100, 16'h0020, 1'b0, "back_to_back");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                   bit'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
